// File: rtl/pdp8_tape_loader_if.sv
// Tape-frame handshake and memory write port between the paper-tape
// reader/memory side (master) and the boot loader (slave).
interface pdp8_tape_loader_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              frame_valid;
  logic [7:0]        frame;
  logic              frame_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [11:0]       mem_wdata;

  modport master (
    output frame_valid, frame,
    input  frame_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  frame_valid, frame,
    output frame_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/pdp8_tape_loader.sv
// PDP-8 BIN paper-tape boot loader.
// Assembles 12-bit origin/data words from pairs of 8-bit tape frames and
// writes data words into core memory, then releases the CPU via cpu_run.
// Optional macro PDP8_LOADER_CHECKSUM_EN: BIN checksum mode. Each data word
// is held pending until the next word completes; the word pending at the
// trailer is the checksum and is compared against the running frame sum.
module pdp8_tape_loader #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  pdp8_tape_loader_if.slave bus,
  output logic              cpu_run,
  output logic              load_err,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEADER,
    S_LO,
    S_HI,
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [5:0]        hi_q, hi_d;
  logic              orig_q, orig_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [11:0]       wdata_q, wdata_d;
`ifdef PDP8_LOADER_CHECKSUM_EN
  logic [11:0]       sum_q, sum_d;
  logic              pend_valid_q, pend_valid_d;
  logic [11:0]       pend_word_q, pend_word_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [11:0]       pend_fsum_q, pend_fsum_d;
  logic [11:0]       frame_sum;
`endif

  logic              accept;
  logic              is_leader;
  logic [11:0]       word;

  assign accept    = bus.frame_valid & bus.frame_ready;
  assign is_leader = (bus.frame == 8'h80);
  assign word      = {hi_q, bus.frame[5:0]};
`ifdef PDP8_LOADER_CHECKSUM_EN
  // Contribution of the two frames forming the word completed this cycle.
  assign frame_sum = {4'h0, 1'b0, orig_q, hi_q} + {4'h0, bus.frame};
`endif

  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = waddr_q;
  assign bus.mem_wdata = wdata_q;

  // State register plus word/address/write-stage datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_SYNC;
      addr_q       <= '0;
      hi_q         <= '0;
      orig_q       <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
`ifdef PDP8_LOADER_CHECKSUM_EN
      sum_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_word_q  <= '0;
      pend_addr_q  <= '0;
      pend_fsum_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      hi_q         <= hi_d;
      orig_q       <= orig_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
`ifdef PDP8_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
      pend_valid_q <= pend_valid_d;
      pend_word_q  <= pend_word_d;
      pend_addr_q  <= pend_addr_d;
      pend_fsum_q  <= pend_fsum_d;
`endif
    end
  end

  // Next-state and datapath update for each accepted frame.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    hi_d         = hi_q;
    orig_d       = orig_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
`ifdef PDP8_LOADER_CHECKSUM_EN
    sum_d        = sum_q;
    pend_valid_d = pend_valid_q;
    pend_word_d  = pend_word_q;
    pend_addr_d  = pend_addr_q;
    pend_fsum_d  = pend_fsum_q;
`endif
    unique case (state_q)
      S_SYNC: begin
        if (accept && is_leader) begin
          state_d = S_LEADER;
        end
      end
      S_LEADER, S_HI: begin
        if (accept) begin
          if (is_leader) begin
            if (state_q == S_HI) begin
`ifdef PDP8_LOADER_CHECKSUM_EN
              // Pending word at the trailer is the checksum; never written.
              if (pend_valid_q && (pend_word_q == sum_q)) begin
                state_d = S_DONE;
              end else begin
                state_d = S_ERR;
              end
`else
              state_d = S_DONE;
`endif
            end
          end else if (bus.frame[7]) begin
            state_d = S_ERR;
          end else begin
            hi_d    = bus.frame[5:0];
            orig_d  = bus.frame[6];
            state_d = S_LO;
          end
        end
      end
      S_LO: begin
        if (accept) begin
          if (bus.frame[7:6] != 2'b00) begin
            state_d = S_ERR;
          end else begin
            state_d = S_HI;
`ifdef PDP8_LOADER_CHECKSUM_EN
            // Completing any word retires the pending data word (if any)
            // into the write stage and folds its frames into the sum.
            if (pend_valid_q) begin
              we_d    = 1'b1;
              waddr_d = pend_addr_q;
              wdata_d = pend_word_q;
            end
            if (orig_q) begin
              addr_d       = ADDR_W'(word);
              sum_d        = sum_q + (pend_valid_q ? pend_fsum_q : 12'h000)
                             + frame_sum;
              pend_valid_d = 1'b0;
            end else begin
              sum_d        = sum_q + (pend_valid_q ? pend_fsum_q : 12'h000);
              pend_valid_d = 1'b1;
              pend_word_d  = word;
              pend_addr_d  = addr_q;
              pend_fsum_d  = frame_sum;
              addr_d       = addr_q + ADDR_W'(1);
            end
`else
            if (orig_q) begin
              addr_d = ADDR_W'(word);
            end else begin
              we_d    = 1'b1;
              waddr_d = addr_q;
              wdata_d = word;
              addr_d  = addr_q + ADDR_W'(1);
            end
`endif
          end
        end
      end
      S_DONE: state_d = S_DONE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    bus.frame_ready = 1'b0;
    cpu_run         = 1'b0;
    load_err        = 1'b0;
    busy            = 1'b0;
    unique case (state_q)
      S_SYNC, S_LEADER: bus.frame_ready = 1'b1;
      S_LO, S_HI: begin
        bus.frame_ready = 1'b1;
        busy            = 1'b1;
      end
      S_DONE:  cpu_run  = 1'b1;
      S_ERR:   load_err = 1'b1;
      default: load_err = 1'b1;
    endcase
  end

endmodule
